// File: rtl/spi_ram_arb_pkg.sv
// Shared types for the SPI/host RAM arbiter: FSM states and requester port ids.
package spi_ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  typedef logic port_id_t;

  localparam port_id_t PORT_SPI  = 1'b0;
  localparam port_id_t PORT_HOST = 1'b1;

endpackage

// File: rtl/spi_ram_arb_picker.sv
// Combinational winner selection between the SPI and host requesters.
// Build option: SPI_RAM_ARB_FIXED_PRIO_EN makes the SPI port win every tie.
module spi_ram_arb_picker
  import spi_ram_arb_pkg::*;
(
  input  logic     r0_req,
  input  logic     r1_req,
  input  port_id_t last_winner,
  output logic     grant_valid,
  output port_id_t winner
);

  // Pick a winner; a lone requester always wins, ties depend on build option.
  always_comb begin
    grant_valid = r0_req | r1_req;
    winner      = PORT_SPI;
    if (r0_req && r1_req) begin
`ifdef SPI_RAM_ARB_FIXED_PRIO_EN
      winner = PORT_SPI;
`else
      winner = (last_winner == PORT_SPI) ? PORT_HOST : PORT_SPI;
`endif
    end else if (r1_req) begin
      winner = PORT_HOST;
    end else begin
      winner = PORT_SPI;
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares one single-port RAM between the SPI command path (port 0) and a host
// path (port 1); one access in flight, sequenced IDLE -> ISSUE -> (RESP) -> IDLE.
// Build option: SPI_RAM_ARB_FIXED_PRIO_EN (fixed SPI priority on ties).
module spi_ram_arbiter
  import spi_ram_arb_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 r0_req,
  input  logic                 r0_we,
  input  logic [ADDR_SIZE-1:0] r0_addr,
  input  logic [MEM_WIDTH-1:0] r0_wdata,
  output logic                 r0_gnt,
  output logic                 r0_rvalid,
  output logic [MEM_WIDTH-1:0] r0_rdata,
  input  logic                 r1_req,
  input  logic                 r1_we,
  input  logic [ADDR_SIZE-1:0] r1_addr,
  input  logic [MEM_WIDTH-1:0] r1_wdata,
  output logic                 r1_gnt,
  output logic                 r1_rvalid,
  output logic [MEM_WIDTH-1:0] r1_rdata,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [MEM_WIDTH-1:0] ram_wdata,
  input  logic [MEM_WIDTH-1:0] ram_rdata,
  output logic                 arb_busy
);

  arb_state_e           state_r, state_s;
  port_id_t             winner_r, winner_s;
  port_id_t             last_winner_r, last_winner_s;
  logic                 pick_valid_s;
  port_id_t             pick_s;
  logic                 r0_gnt_s, r1_gnt_s, r0_rvalid_s, r1_rvalid_s;
  logic                 ram_en_s, ram_we_s;
  logic [ADDR_SIZE-1:0] ram_addr_s;
  logic [MEM_WIDTH-1:0] ram_wdata_s, r0_rdata_s, r1_rdata_s;

  spi_ram_arb_picker u_picker (
    .r0_req      (r0_req),
    .r1_req      (r1_req),
    .last_winner (last_winner_r),
    .grant_valid (pick_valid_s),
    .winner      (pick_s)
  );

  // Next state plus next value of every registered output.
  always_comb begin
    state_s       = state_r;
    winner_s      = winner_r;
    last_winner_s = last_winner_r;
    r0_gnt_s      = 1'b0;
    r1_gnt_s      = 1'b0;
    r0_rvalid_s   = 1'b0;
    r1_rvalid_s   = 1'b0;
    r0_rdata_s    = r0_rdata;
    r1_rdata_s    = r1_rdata;
    ram_en_s      = 1'b0;
    ram_we_s      = 1'b0;
    ram_addr_s    = ram_addr;
    ram_wdata_s   = ram_wdata;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_s       = ISSUE;
          winner_s      = pick_s;
          last_winner_s = pick_s;
          ram_en_s      = 1'b1;
          if (pick_s == PORT_SPI) begin
            r0_gnt_s    = 1'b1;
            ram_we_s    = r0_we;
            ram_addr_s  = r0_addr;
            ram_wdata_s = r0_we ? r0_wdata : {MEM_WIDTH{1'b0}};
          end else begin
            r1_gnt_s    = 1'b1;
            ram_we_s    = r1_we;
            ram_addr_s  = r1_addr;
            ram_wdata_s = r1_we ? r1_wdata : {MEM_WIDTH{1'b0}};
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        // ram_we still reflects the access being issued this cycle.
        state_s = ram_we ? IDLE : RESP;
      end
      RESP: begin
        state_s = IDLE;
        if (winner_r == PORT_SPI) begin
          r0_rvalid_s = 1'b1;
          r0_rdata_s  = ram_rdata;
        end else begin
          r1_rvalid_s = 1'b1;
          r1_rdata_s  = ram_rdata;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      winner_r      <= PORT_SPI;
      last_winner_r <= PORT_HOST;
      r0_gnt        <= 1'b0;
      r1_gnt        <= 1'b0;
      r0_rvalid     <= 1'b0;
      r1_rvalid     <= 1'b0;
      r0_rdata      <= {MEM_WIDTH{1'b0}};
      r1_rdata      <= {MEM_WIDTH{1'b0}};
      ram_en        <= 1'b0;
      ram_we        <= 1'b0;
      ram_addr      <= {ADDR_SIZE{1'b0}};
      ram_wdata     <= {MEM_WIDTH{1'b0}};
      arb_busy      <= 1'b0;
    end else begin
      state_r       <= state_s;
      winner_r      <= winner_s;
      last_winner_r <= last_winner_s;
      r0_gnt        <= r0_gnt_s;
      r1_gnt        <= r1_gnt_s;
      r0_rvalid     <= r0_rvalid_s;
      r1_rvalid     <= r1_rvalid_s;
      r0_rdata      <= r0_rdata_s;
      r1_rdata      <= r1_rdata_s;
      ram_en        <= ram_en_s;
      ram_we        <= ram_we_s;
      ram_addr      <= ram_addr_s;
      ram_wdata     <= ram_wdata_s;
      arb_busy      <= (state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed self-checking bench for spi_ram_arbiter with a 1-cycle-latency RAM model.
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
  logic [7:0] r0_addr = 8'h00, r0_wdata = 8'h00, r1_addr = 8'h00, r1_wdata = 8'h00;
  logic       r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [7:0] r0_rdata, r1_rdata;
  logic       ram_en, ram_we, arb_busy;
  logic [7:0] ram_addr, ram_wdata;
  logic [7:0] ram_rdata = 8'h00;
  logic [7:0] mem [0:255];

  int n_checks = 0;
  int n_pass   = 0;

  spi_ram_arbiter #(.ADDR_SIZE(8), .MEM_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  // Single-port RAM model: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata,
                ram_en, ram_we, ram_addr, ram_wdata, arb_busy});
  endfunction

  initial begin
    logic [7:0] seq [0:7];
    logic [7:0] exp_port;
    int ng, c0, c1, cnt_en, cnt_g0, cnt_rv1;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;

    #3 rst_n = 1'b0;
    #4 check("reset_outs", all_outs(), 64'd0);
    step(); step();
    @(negedge clk) rst_n = 1'b1;
    step();

    // Single write from port 0.
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'h12; r0_wdata = 8'hA5;
    step();
    check("wr_gnt", 64'({r0_gnt, r1_gnt}), 64'(2'b10));
    check("wr_ram", 64'({ram_en, ram_we, ram_addr, ram_wdata}), 64'({1'b1, 1'b1, 8'h12, 8'hA5}));
    check("wr_busy", 64'(arb_busy), 64'(1'b1));
    r0_req = 1'b0;
    step();
    check("wr_done", 64'({arb_busy, ram_en, ram_we, r0_gnt, ram_addr}), 64'({4'b0000, 8'h12}));

    // Port 1 reads back the written location.
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h12; r1_wdata = 8'h77;
    step();
    check("rd_gnt", 64'({r1_gnt, r0_gnt, ram_en, ram_we, ram_wdata}), 64'({4'b1010, 8'h00}));
    r1_req = 1'b0;
    step();
    check("rd_resp", 64'({r1_rvalid, arb_busy, ram_en}), 64'(3'b010));
    step();
    check("rd_valid", 64'({r1_rvalid, r1_rdata, r0_rvalid, r0_rdata}), 64'({1'b1, 8'hA5, 1'b0, 8'h00}));
    check("rd_idle", 64'(arb_busy), 64'(1'b0));
    step();
    check("rd_hold", 64'({r1_rvalid, r1_rdata}), 64'({1'b0, 8'hA5}));

    // Both ports stream 4 reads each.
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h20;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h21;
    c0 = 4; c1 = 4; ng = 0;
    for (int cyc = 0; cyc < 40 && ng < 8; cyc++) begin
      step();
      if (r0_gnt && r1_gnt) check("dual_gnt", 64'd1, 64'd0);
      if (r0_gnt) begin seq[ng] = 8'd0; ng++; c0--; if (c0 == 0) r0_req = 1'b0; end
      if (r1_gnt) begin seq[ng] = 8'd1; ng++; c1--; if (c1 == 0) r1_req = 1'b0; end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    check("rr_count", 64'(ng), 64'(8));
    for (int i = 0; i < 8; i++) begin
`ifdef SPI_RAM_ARB_FIXED_PRIO_EN
      exp_port = (i < 4) ? 8'd0 : 8'd1;
`else
      exp_port = 8'(i % 2);
`endif
      if (i < ng) check($sformatf("rr_seq%0d", i), 64'(seq[i]), 64'(exp_port));
    end
    step(); step(); step();

    // Port 1 arrives during a port-0 read ISSUE cycle.
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h30;
    step();
    check("late_g0", 64'({r0_gnt, r1_gnt}), 64'(2'b10));
    r0_req = 1'b0; r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h12;
    step();
    check("late_resp", 64'(r1_gnt), 64'(1'b0));
    step();
    check("late_rv0", 64'({r0_rvalid, r0_rdata, r1_gnt}), 64'({1'b1, 8'h0C, 1'b0}));
    step();
    check("late_g1", 64'({r1_gnt, r0_gnt}), 64'(2'b10));
    r1_req = 1'b0;
    step(); step(); step();

    // Reset during RESP of a port-0 read.
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h12;
    step();
    check("rst_g0", 64'(r0_gnt), 64'(1'b1));
    r0_req = 1'b0;
    step();
    check("rst_inresp", 64'({arb_busy, r0_rvalid}), 64'(2'b10));
    #2 rst_n = 1'b0;
    #1 check("rst_mid_outs", all_outs(), 64'd0);
    step();
    check("rst_no_rv", 64'(r0_rvalid), 64'(1'b0));
    @(negedge clk) rst_n = 1'b1;
    step();
    check("rst_after", 64'({r0_rvalid, arb_busy}), 64'(2'b00));
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h01;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h02;
    step();
    check("rst_first_g", 64'({r0_gnt, r1_gnt}), 64'(2'b10));
    r0_req = 1'b0;
    step(); step(); step();
    check("rst_then_g1", 64'(r1_gnt), 64'(1'b1));
    r1_req = 1'b0;
    step(); step(); step();

    // Port 0 withdraws its request before being granted.
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h40;
    step();
    check("drop_g1", 64'(r1_gnt), 64'(1'b1));
    r1_req = 1'b0; r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'h50; r0_wdata = 8'h11;
    step();
    r0_req = 1'b0;
    cnt_en = 0; cnt_g0 = 0; cnt_rv1 = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ram_en) cnt_en++;
      if (r0_gnt) cnt_g0++;
      if (r1_rvalid) cnt_rv1++;
    end
    check("drop_no_en", 64'(cnt_en), 64'(0));
    check("drop_no_g0", 64'(cnt_g0), 64'(0));
    check("drop_rv1", 64'(cnt_rv1), 64'(1));
    check("drop_mem", 64'(mem[8'h50]), 64'(8'h50 ^ 8'h3C));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
